// File: rtl/det_event_counter.sv
// Windowed rising-edge counter for the "111" sequence detector match output.
// Define DET_CNT_SATURATE_EN to saturate the count and report overflow on ovf.
module det_event_counter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             en,
   input  logic             det_in,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] cnt_out,
   output logic             odd,
   output logic             even,
   output logic             ovf,
   output logic             rpt_valid,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             det_q, det_d;
   logic [WIN_W-1:0] cyc_q, cyc_d;
   logic [WIN_W-1:0] win_ld_q, win_ld_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
   logic             busy_q, busy_d;
   logic             rpt_q, rpt_d;

   logic             hit;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIN_W-1:0] win_eff;
   logic             start_win;

   assign hit     = det_in & ~det_q;
   assign win_eff = (win_len == '0) ? WIN_W'(1) : win_len;

`ifdef DET_CNT_SATURATE_EN
   logic sat_q, sat_d;
   logic ovf_q, ovf_d;
   logic ovf_hit;

   assign cnt_inc = (hit && (run_cnt_q != '1)) ? run_cnt_q + CNT_W'(1) : run_cnt_q;
   // Sticky flag including a hit on the current cycle, so the final cycle counts.
   assign ovf_hit = sat_q | (hit & (run_cnt_q == '1));
   assign ovf     = ovf_q;
`else
   assign cnt_inc = run_cnt_q + CNT_W'(hit);
   assign ovf     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      det_d     = det_in;
      cyc_d     = cyc_q;
      win_ld_d  = win_ld_q;
      run_cnt_d = run_cnt_q;
      cnt_out_d = cnt_out_q;
      start_win = 1'b0;
`ifdef DET_CNT_SATURATE_EN
      sat_d     = sat_q;
      ovf_d     = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (en) begin
               start_win = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else begin
               run_cnt_d = cnt_inc;
               cyc_d     = cyc_q + WIN_W'(1);
`ifdef DET_CNT_SATURATE_EN
               sat_d     = ovf_hit;
`endif
               if (cyc_q == win_ld_q - WIN_W'(1)) begin
                  cnt_out_d = cnt_inc;
`ifdef DET_CNT_SATURATE_EN
                  ovf_d     = ovf_hit;
`endif
                  state_d   = REPORT;
               end
            end
         end
         REPORT: begin
            // Dead cycle: any hit here is dropped; only det_q advances.
            if (en) begin
               start_win = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_win) begin
         state_d   = RUN;
         win_ld_d  = win_eff;
         cyc_d     = '0;
         run_cnt_d = '0;
`ifdef DET_CNT_SATURATE_EN
         sat_d     = 1'b0;
`endif
      end

      busy_d = (state_d != IDLE);
      rpt_d  = (state_d == REPORT);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q   <= IDLE;
         det_q     <= 1'b0;
         cyc_q     <= '0;
         win_ld_q  <= '0;
         run_cnt_q <= '0;
         cnt_out_q <= '0;
         busy_q    <= 1'b0;
         rpt_q     <= 1'b0;
`ifdef DET_CNT_SATURATE_EN
         sat_q     <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         det_q     <= det_d;
         cyc_q     <= cyc_d;
         win_ld_q  <= win_ld_d;
         run_cnt_q <= run_cnt_d;
         cnt_out_q <= cnt_out_d;
         busy_q    <= busy_d;
         rpt_q     <= rpt_d;
`ifdef DET_CNT_SATURATE_EN
         sat_q     <= sat_d;
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign cnt_out   = cnt_out_q;
   assign odd       = cnt_out_q[0];
   assign even      = ~cnt_out_q[0];
   assign rpt_valid = rpt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_det_event_counter.sv
// Directed bench for det_event_counter: an 8-bit counter plus a 3-bit one
// sharing the same stimulus, the latter exercising wrap/saturation.
module tb_det_event_counter;

   logic       clk = 1'b0;
   logic       arstn;
   logic       en;
   logic       det_in;
   logic [7:0] win_len;

   logic [7:0] cnt_out;
   logic       odd, even, ovf, rpt_valid, busy;
   logic [2:0] cnt3_out;
   logic       odd3, even3, ovf3, rpt3_valid, busy3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   det_event_counter #(.CNT_W(8), .WIN_W(8)) dut (
      .clk(clk), .arstn(arstn), .en(en), .det_in(det_in), .win_len(win_len),
      .cnt_out(cnt_out), .odd(odd), .even(even), .ovf(ovf),
      .rpt_valid(rpt_valid), .busy(busy)
   );

   det_event_counter #(.CNT_W(3), .WIN_W(8)) dut3 (
      .clk(clk), .arstn(arstn), .en(en), .det_in(det_in), .win_len(win_len),
      .cnt_out(cnt3_out), .odd(odd3), .even(even3), .ovf(ovf3),
      .rpt_valid(rpt3_valid), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive det_in for one cycle, then sample 1 time unit after the edge.
   task automatic cyc(input logic d);
      det_in = d;
      @(posedge clk);
      #1;
   endtask

   // One window report: strobe, count and parity.
   task automatic chk_report(input string tag, input int exp_cnt);
      check({tag, "_rpt"}, rpt_valid, 1);
      check({tag, "_cnt"}, cnt_out, exp_cnt);
      check({tag, "_odd"}, odd, exp_cnt % 2);
      check({tag, "_even"}, even, 1 - (exp_cnt % 2));
      $display("[TB] window %s: cnt_out=%0d odd=%0d even=%0d ovf=%0d", tag, cnt_out, odd, even, ovf);
   endtask

   task automatic run_pattern(input logic [63:0] pat, input int len);
      for (int i = 0; i < len; i++) begin
         cyc(pat[i]);
      end
   endtask

   initial begin
      arstn   = 1'b0;
      en      = 1'b1;
      det_in  = 1'b0;
      win_len = 8'd10;

      // Reset held with en high and det_in toggling
      for (int i = 0; i < 4; i++) cyc(i[0]);
      check("rst_cnt", cnt_out, 0);
      check("rst_even", even, 1);
      check("rst_odd", odd, 0);
      check("rst_ovf", ovf, 0);
      check("rst_rpt", rpt_valid, 0);
      check("rst_busy", busy, 0);
      $display("[TB] reset held: busy=%0d cnt_out=%0d", busy, cnt_out);

      en    = 1'b0;
      arstn = 1'b1;
      cyc(0);
      cyc(0);
      check("idle_busy", busy, 0);

      // Three separated pulses in a 10-cycle window (bit i = RUN cycle i+1)
      win_len = 8'd10;
      en      = 1'b1;
      cyc(0);
      check("t2_busy", busy, 1);
      run_pattern(64'b0000101010, 9);
      check("t2_rpt_early", rpt_valid, 0);
      cyc(0);
      chk_report("t2", 3);
      en = 1'b0;
      cyc(0);
      check("t2_rpt_one", rpt_valid, 0);
      check("t2_busy_off", busy, 0);
      check("t2_hold", cnt_out, 3);

      // Held level counts once, plus one separate pulse
      win_len = 8'd12;
      en      = 1'b1;
      cyc(0);
      run_pattern(64'b000010011111, 12);
      chk_report("t3", 2);

      // Edge on last window cycle counts; REPORT-cycle edge is dropped
      win_len = 8'd6;
      en      = 1'b0;
      cyc(0);
      en = 1'b1;
      cyc(0);
      run_pattern(64'b100000, 6);
      chk_report("t4_last", 1);
      cyc(0);
      run_pattern(64'b000000, 6);
      chk_report("t4_zero", 0);
      cyc(1);
      check("t4_rpt_drop", rpt_valid, 0);
      run_pattern(64'b111111, 6);
      chk_report("t4_dead", 0);

      // win_len = 0 behaves as 1: report every second cycle
      win_len = 8'd0;
      cyc(0);
      check("t4_w0_run", rpt_valid, 0);
      cyc(1);
      chk_report("t4_w0_a", 1);
      cyc(0);
      check("t4_w0_gap", rpt_valid, 0);
      cyc(1);
      chk_report("t4_w0_b", 1);
      en = 1'b0;
      cyc(0);
      check("t4_idle", busy, 0);

      // Abort: report 3, then drop en mid-window
      win_len = 8'd5;
      en      = 1'b1;
      cyc(0);
      run_pattern(64'b10101, 5);
      chk_report("t5", 3);
      en = 1'b0;
      cyc(0);
      en = 1'b1;
      cyc(0);
      run_pattern(64'b0101, 4);
      en = 1'b0;
      cyc(0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_rpt", rpt_valid, 0);
      check("t5_abort_cnt", cnt_out, 3);
      cyc(0);
      cyc(0);
      check("t5_no_rpt", rpt_valid, 0);
      check("t5_keep", cnt_out, 3);
      $display("[TB] abort: busy=%0d cnt_out=%0d", busy, cnt_out);

      // Ten pulses in a 40-cycle window on both counter widths
      win_len = 8'd40;
      en      = 1'b1;
      cyc(0);
      for (int i = 0; i < 40; i++) cyc((i % 4) == 1);
      chk_report("t6_w8", 10);
      check("t6_w8_ovf", ovf, 0);
      check("t6_w3_rpt", rpt3_valid, 1);
`ifdef DET_CNT_SATURATE_EN
      check("t6_w3_cnt", cnt3_out, 7);
      check("t6_w3_ovf", ovf3, 1);
      check("t6_w3_odd", odd3, 1);
`else
      check("t6_w3_cnt", cnt3_out, 2);
      check("t6_w3_ovf", ovf3, 0);
      check("t6_w3_odd", odd3, 0);
`endif
      $display("[TB] window t6_w3: cnt_out=%0d ovf=%0d", cnt3_out, ovf3);

      // Asynchronous reset mid-RUN, asserted between clock edges
      cyc(0);
      cyc(1);
      check("t1_mid_busy_pre", busy, 1);
      #3;
      arstn = 1'b0;
      #1;
      check("t1_mid_busy", busy, 0);
      check("t1_mid_cnt", cnt_out, 0);
      check("t1_mid_even", even, 1);
      check("t1_mid_odd", odd, 0);
      check("t1_mid_rpt", rpt_valid, 0);
      check("t1_mid_cnt3", cnt3_out, 0);
      check("t1_mid_ovf3", ovf3, 0);
      $display("[TB] async reset: busy=%0d cnt_out=%0d", busy, cnt_out);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
